// File: rtl/if_fetch_queue.sv
// if_fetch_queue: decoupled instruction-fetch front end.
// Issues block-aligned fetch requests with up to MAX_OUTST in flight, buffers
// the returned fetch groups in an FQ_DEPTH-entry circular queue and presents
// the head group to decode. A redirect flushes the queue and arranges for the
// responses still in flight to be dropped when they return.
module if_fetch_queue #(
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned FQ_DEPTH    = 8,
    parameter int unsigned MAX_OUTST   = 2,
    parameter logic [31:0] RESET_PC    = 32'h1c000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        redirect_valid,
    input  logic [31:0]                 redirect_pc,
    input  logic                        fetch_hold,
    output logic                        inst_valid,
    output logic [31:0]                 inst_addr,
    input  logic                        inst_addr_ok,
    input  logic                        inst_data_ok,
    input  logic [32*FETCH_WIDTH-1:0]   inst_rdata,
    input  logic                        inst_excp,
    input  logic [3:0]                  inst_excp_num,
    output logic                        fq_out_valid,
    output logic [31:0]                 fq_out_pc,
    output logic [32*FETCH_WIDTH-1:0]   fq_out_inst,
    output logic [FETCH_WIDTH-1:0]      fq_out_mask,
    output logic                        fq_out_excp,
    output logic [3:0]                  fq_out_excp_num,
    input  logic                        ds_allowin,
    output logic [$clog2(FQ_DEPTH):0]   fq_count
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int unsigned BLK    = FETCH_WIDTH * 4;
    localparam int unsigned SLOT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int unsigned FQ_PW  = $clog2(FQ_DEPTH);
    localparam int unsigned CNT_W  = FQ_PW + 1;
    localparam int unsigned CRD_W  = CNT_W + 1;
    localparam int unsigned RQ_PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned OUT_W  = $clog2(MAX_OUTST + 1);
    // Back-to-back redirects can stack stale responses beyond MAX_OUTST, so
    // the discard counter is sized generously rather than to MAX_OUTST.
    localparam int unsigned DISC_W = 8;

    localparam logic [31:0]            ALIGN_MASK = ~(32'(BLK) - 32'd1);
    localparam logic [FETCH_WIDTH-1:0] ALL_ONES   = '1;
    localparam logic [FETCH_WIDTH-1:0] SLOT0      = FETCH_WIDTH'(1);
    localparam logic [SLOT_W-1:0]      SLOT_SEL   = SLOT_W'(FETCH_WIDTH - 1);

    // ------------------------------------------------------------------
    // Types
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0]            pc;
        logic [FETCH_WIDTH-1:0] mask;
    } req_t;

    typedef struct packed {
        logic [31:0]              pc;
        logic [32*FETCH_WIDTH-1:0] inst;
        logic [FETCH_WIDTH-1:0]   mask;
        logic                     excp;
        logic [3:0]               excp_num;
    } fq_entry_t;

    // Address-error handling: RUN issues normally, ADEF_WAIT waits for stale
    // responses to drain before posting the error entry, ADEF_HOLD blocks
    // issue until the next redirect.
    typedef enum logic [1:0] {
        ST_RUN,
        ST_ADEF_WAIT,
        ST_ADEF_HOLD
    } adef_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]            fetch_pc;
    logic [FETCH_WIDTH-1:0] first_mask;
    logic [OUT_W-1:0]       outstanding;
    logic [DISC_W-1:0]      discard;

    req_t                   rq_mem [MAX_OUTST];
    logic [RQ_PW-1:0]       rq_head;
    logic [RQ_PW-1:0]       rq_tail;

    fq_entry_t              fq_mem [FQ_DEPTH];
    logic [FQ_PW-1:0]       fq_head;
    logic [FQ_PW-1:0]       fq_tail;

    adef_state_t            state;
    adef_state_t            state_nxt;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [31:0]            fetch_pc_aligned;
    logic [SLOT_W-1:0]      fetch_slot;
    logic [SLOT_W-1:0]      redirect_slot;
    logic                   redirect_misaligned;
    logic [CRD_W-1:0]       credit_sum;
    logic                   handshake;
    logic                   resp_live;
    logic                   resp_drop;
    logic                   adef_enq;
    logic                   enq_valid;
    logic                   deq_valid;
    fq_entry_t              enq_entry;
    logic [DISC_W-1:0]      disc_redirect;

    function automatic logic [RQ_PW-1:0] rq_inc(input logic [RQ_PW-1:0] ptr);
        return (ptr == RQ_PW'(MAX_OUTST - 1)) ? '0 : ptr + RQ_PW'(1);
    endfunction

    assign fetch_pc_aligned    = fetch_pc & ALIGN_MASK;
    assign inst_addr           = fetch_pc_aligned;
    assign fetch_slot          = SLOT_W'(fetch_pc >> 2) & SLOT_SEL;
    assign redirect_slot       = SLOT_W'(redirect_pc >> 2) & SLOT_SEL;
    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

    // Issue credit: every in-flight request already owns a queue slot, so
    // the queue can never overflow when its response returns.
    assign credit_sum = CRD_W'(fq_count) + CRD_W'(outstanding);

    assign inst_valid = !reset && !redirect_valid && !fetch_hold
                        && (state == ST_RUN)
                        && (outstanding < OUT_W'(MAX_OUTST))
                        && (credit_sum < CRD_W'(FQ_DEPTH));

    assign handshake = inst_valid && inst_addr_ok;
    assign resp_live = inst_data_ok && (discard == '0);
    assign resp_drop = inst_data_ok && (discard != '0);
    assign enq_valid = !redirect_valid && (resp_live || adef_enq);
    assign deq_valid = !redirect_valid && fq_out_valid && ds_allowin;

    // Select the entry to enqueue: either a live cache response or the
    // synthetic address-error entry.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        enq_entry = '0;
        if (adef_enq) begin
            enq_entry.pc       = fetch_pc_aligned;
            enq_entry.mask     = SLOT0 << fetch_slot;
            enq_entry.excp     = 1'b1;
            enq_entry.excp_num = 4'h1;
        end else begin
            enq_entry.pc       = rq_mem[rq_head].pc;
            enq_entry.inst     = inst_rdata;
            enq_entry.mask     = rq_mem[rq_head].mask;
            enq_entry.excp     = inst_excp;
            enq_entry.excp_num = inst_excp_num;
        end
    end

    // Stale-response count after a redirect: everything in flight becomes
    // stale, minus the response (live or stale) consumed this very cycle.
    always_comb begin
        disc_redirect = discard + DISC_W'(outstanding);
        if (inst_data_ok && (disc_redirect != '0)) begin
            disc_redirect = disc_redirect - DISC_W'(1);
        end
    end

    // Address-error FSM next state and error-entry strobe; redirect wins.
    always_comb begin
        state_nxt = state;
        adef_enq  = 1'b0;
        case (state)
            ST_ADEF_WAIT: begin
                if (discard == '0) begin
                    adef_enq  = 1'b1;
                    state_nxt = ST_ADEF_HOLD;
                end
            end
            default: ;
        endcase
        if (redirect_valid) begin
            adef_enq  = 1'b0;
            state_nxt = redirect_misaligned ? ST_ADEF_WAIT : ST_RUN;
        end
    end

    // Address-error FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch PC, first-group mask, in-flight and stale-response counters,
    // and the per-request FIFO pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            first_mask  <= ALL_ONES;
            outstanding <= '0;
            discard     <= '0;
            rq_head     <= '0;
            rq_tail     <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_pc;
            first_mask  <= ALL_ONES << redirect_slot;
            outstanding <= '0;
            discard     <= disc_redirect;
            rq_head     <= '0;
            rq_tail     <= '0;
        end else begin
            if (handshake) begin
                fetch_pc   <= fetch_pc_aligned + 32'(BLK);
                first_mask <= ALL_ONES;
                rq_tail    <= rq_inc(rq_tail);
            end
            if (resp_live) begin
                rq_head <= rq_inc(rq_head);
            end
            if (resp_drop) begin
                discard <= discard - DISC_W'(1);
            end
            outstanding <= outstanding + OUT_W'(handshake) - OUT_W'(resp_live);
        end
    end

    // Per-request PC/mask storage, written at issue.
    always_ff @(posedge clk) begin
        if (handshake) begin
            rq_mem[rq_tail] <= '{pc: fetch_pc_aligned, mask: first_mask};
        end
    end

    // Fetch-queue pointers and occupancy; a redirect empties the queue and
    // overrides any push or pop in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fq_head  <= '0;
            fq_tail  <= '0;
            fq_count <= '0;
        end else if (redirect_valid) begin
            fq_head  <= '0;
            fq_tail  <= '0;
            fq_count <= '0;
        end else begin
            if (enq_valid) begin
                fq_tail <= fq_tail + FQ_PW'(1);
            end
            if (deq_valid) begin
                fq_head <= fq_head + FQ_PW'(1);
            end
            fq_count <= fq_count + CNT_W'(enq_valid) - CNT_W'(deq_valid);
        end
    end

    // Fetch-queue payload storage.
    always_ff @(posedge clk) begin
        // NOTE: the payload array is not reset; an entry is only observable
        // while fq_count says it is occupied, and the outputs are gated on that.
        if (enq_valid) begin
            fq_mem[fq_tail] <= enq_entry;
        end
    end

    // Present the head entry to decode, zero when the queue is empty.
    always_comb begin
        fq_out_valid    = (fq_count != '0);
        fq_out_pc       = '0;
        fq_out_inst     = '0;
        fq_out_mask     = '0;
        fq_out_excp     = 1'b0;
        fq_out_excp_num = '0;
        if (fq_out_valid) begin
            fq_out_pc       = fq_mem[fq_head].pc;
            fq_out_inst     = fq_mem[fq_head].inst;
            fq_out_mask     = fq_mem[fq_head].mask;
            fq_out_excp     = fq_mem[fq_head].excp;
            fq_out_excp_num = fq_mem[fq_head].excp_num;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: self-checking bench for if_fetch_queue with an in-order
// icache model and a scoreboard of the groups decode must receive.
module tb_if_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_hold;
    logic        inst_valid;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [63:0] inst_rdata;
    logic        inst_excp;
    logic [3:0]  inst_excp_num;
    logic        fq_out_valid;
    logic [31:0] fq_out_pc;
    logic [63:0] fq_out_inst;
    logic [1:0]  fq_out_mask;
    logic        fq_out_excp;
    logic [3:0]  fq_out_excp_num;
    logic        ds_allowin;
    logic [3:0]  fq_count;

    if_fetch_queue dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .fetch_hold      (fetch_hold),
        .inst_valid      (inst_valid),
        .inst_addr       (inst_addr),
        .inst_addr_ok    (inst_addr_ok),
        .inst_data_ok    (inst_data_ok),
        .inst_rdata      (inst_rdata),
        .inst_excp       (inst_excp),
        .inst_excp_num   (inst_excp_num),
        .fq_out_valid    (fq_out_valid),
        .fq_out_pc       (fq_out_pc),
        .fq_out_inst     (fq_out_inst),
        .fq_out_mask     (fq_out_mask),
        .fq_out_excp     (fq_out_excp),
        .fq_out_excp_num (fq_out_excp_num),
        .ds_allowin      (ds_allowin),
        .fq_count        (fq_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [1:0]  mask;
        int          epoch;
        int          ready;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [63:0] inst;
        logic [1:0]  mask;
        logic        excp;
        logic [3:0]  num;
    } exp_t;

    typedef struct {
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [1:0]  mask;
        logic        excp;
    } vec_t;

    pend_t       pend[$];
    exp_t        sb[$];
    logic [31:0] hs_log[$];
    logic [31:0] pop_log[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          resp_lat = 1;
    int          max_count = 0;
    bit          stall = 1'b0;
    bit          saw_valid = 1'b0;
    logic [31:0] exp_addr = RESET_PC;
    logic [1:0]  exp_fmask = 2'b11;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock cycle: drive the cache side, observe handshake / response /
    // pop against the model, then advance past the rising edge.
    task automatic step();
        pend_t r;
        exp_t  e;
        bit    rsp;
        bit    pop;
        @(negedge clk);
        inst_addr_ok  = 1'b1;
        rsp           = !stall && (pend.size() > 0) && (pend[0].ready <= cyc);
        inst_data_ok  = rsp;
        inst_rdata    = rsp ? {pend[0].addr + 32'd4, pend[0].addr} : 64'd0;
        inst_excp     = 1'b0;
        inst_excp_num = 4'h0;
        #1;
        if (int'(fq_count) > max_count) max_count = int'(fq_count);
        if (inst_valid) saw_valid = 1'b1;
        if (redirect_valid) check("no_issue_on_redirect", 64'(inst_valid), 64'd0);
        if (inst_valid && inst_addr_ok) begin
            check("issue_addr", 64'(inst_addr), 64'(exp_addr));
            hs_log.push_back(inst_addr);
            r = '{addr: inst_addr, pc: exp_addr, mask: exp_fmask, epoch: epoch, ready: cyc + resp_lat};
            pend.push_back(r);
            exp_addr  = exp_addr + 32'd8;
            exp_fmask = 2'b11;
        end
        pop = fq_out_valid && ds_allowin && !redirect_valid;
        if (pop) begin
            pop_log.push_back(fq_out_pc);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_entry: got pc %0h, required no entry (cycle %0d)", fq_out_pc, cyc);
            end else begin
                e = sb.pop_front();
                check("out_pc", 64'(fq_out_pc), 64'(e.pc));
                check("out_inst", fq_out_inst, e.inst);
                check("out_mask", 64'(fq_out_mask), 64'(e.mask));
                check("out_excp", 64'({fq_out_excp, fq_out_excp_num}), 64'({e.excp, e.num}));
            end
        end
        if (rsp) begin
            r = pend.pop_front();
            if (r.epoch == epoch && !redirect_valid)
                sb.push_back('{pc: r.pc, inst: {r.pc + 32'd4, r.pc}, mask: r.mask, excp: 1'b0, num: 4'h0});
        end
        if (redirect_valid) begin
            epoch++;
            sb.delete();
            exp_addr  = redirect_pc & ~32'h7;
            exp_fmask = redirect_pc[2] ? 2'b10 : 2'b11;
            if (redirect_pc[1:0] != 2'b00)
                sb.push_back('{pc: redirect_pc & ~32'h7, inst: 64'd0,
                               mask: redirect_pc[2] ? 2'b10 : 2'b01, excp: 1'b1, num: 4'h1});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!fq_out_valid && n < budget) begin
            step();
            n++;
        end
        if (!fq_out_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: fq_out_valid still 0 after %0d cycles, required 1", name, budget);
        end
    endtask

    vec_t        vecs [6];
    logic [31:0] exp_seq [3];

    initial begin
        vecs[0] = '{tgt: 32'h1c000104, pc: 32'h1c000100, mask: 2'b10, excp: 1'b0};
        vecs[1] = '{tgt: 32'h1c000200, pc: 32'h1c000200, mask: 2'b11, excp: 1'b0};
        vecs[2] = '{tgt: 32'h1c000102, pc: 32'h1c000100, mask: 2'b01, excp: 1'b1};
        vecs[3] = '{tgt: 32'h1c00030c, pc: 32'h1c000308, mask: 2'b10, excp: 1'b0};
        vecs[4] = '{tgt: 32'h1c000306, pc: 32'h1c000300, mask: 2'b10, excp: 1'b1};
        vecs[5] = '{tgt: 32'h1c000400, pc: 32'h1c000400, mask: 2'b11, excp: 1'b0};
        exp_seq[0] = 32'h1c000000;
        exp_seq[1] = 32'h1c000008;
        exp_seq[2] = 32'h1c000010;

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        fetch_hold     = 1'b0;
        ds_allowin     = 1'b0;
        inst_addr_ok   = 1'b0;
        inst_data_ok   = 1'b0;
        inst_rdata     = 64'd0;
        inst_excp      = 1'b0;
        inst_excp_num  = 4'h0;

        // Reset state.
        repeat (2) step();
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst_addr", 64'(inst_addr), 64'(RESET_PC));
        check("rst_fq_valid", 64'(fq_out_valid), 64'd0);
        check("rst_fq_count", 64'(fq_count), 64'd0);
        check("rst_fq_pc", 64'(fq_out_pc), 64'd0);
        check("rst_fq_mask", 64'(fq_out_mask), 64'd0);

        // Streaming from reset with an always-ready cache.
        reset      = 1'b0;
        ds_allowin = 1'b1;
        repeat (12) step();
        for (int i = 0; i < 3; i++) begin
            check("boot_issue_seq", 64'(hs_log[i]), 64'(exp_seq[i]));
            check("boot_out_seq", 64'(pop_log[i]), 64'(exp_seq[i]));
        end

        // Decode stalled: queue fills to capacity, issue stops.
        ds_allowin = 1'b0;
        max_count  = 0;
        repeat (20) step();
        check("full_count", 64'(fq_count), 64'd8);
        check("full_max_count", 64'(max_count), 64'd8);
        check("full_no_issue", 64'(inst_valid), 64'd0);
        ds_allowin = 1'b1;
        repeat (10) step();
        // Hold new fetches and let everything in flight land and drain.
        fetch_hold = 1'b1;
        repeat (14) step();
        check("hold_no_issue", 64'(inst_valid), 64'd0);
        check("drain_count", 64'(fq_count), 64'd0);
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
        check("drain_pend_empty", 64'(pend.size()), 64'd0);
        fetch_hold = 1'b0;

        // Redirect table: two requests parked in the cache, then redirect.
        for (int i = 0; i < 6; i++) begin
            ds_allowin = 1'b0;
            stall      = 1'b1;
            repeat (4) step();
            redirect_valid = 1'b1;
            redirect_pc    = vecs[i].tgt;
            step();
            redirect_valid = 1'b0;
            stall          = 1'b0;
            wait_valid("vec_wait", 40);
            check("vec_pc", 64'(fq_out_pc), 64'(vecs[i].pc));
            check("vec_mask", 64'(fq_out_mask), 64'(vecs[i].mask));
            check("vec_excp", 64'(fq_out_excp), 64'(vecs[i].excp));
            if (vecs[i].excp) begin
                check("vec_excp_num", 64'(fq_out_excp_num), 64'h1);
                saw_valid = 1'b0;
                repeat (10) step();
                check("adef_no_issue", 64'(saw_valid), 64'd0);
                check("adef_single_entry", 64'(fq_count), 64'd1);
            end
            ds_allowin = 1'b1;
            repeat (6) step();
        end

        // Redirect in the same cycle as a live response, two in flight.
        stall = 1'b1;
        repeat (4) step();
        check("two_in_flight", 64'(pend.size()), 64'd2);
        stall          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1c000500;
        step();
        redirect_valid = 1'b0;
        stall          = 1'b1;
        repeat (3) step();
        check("redir_resp_empty", 64'(fq_count), 64'd0);
        stall = 1'b0;
        wait_valid("redir_resp_wait", 40);
        check("redir_resp_pc", 64'(fq_out_pc), 64'h1c000500);
        check("redir_resp_mask", 64'(fq_out_mask), 64'(2'b11));
        repeat (6) step();

        // Asynchronous reset pulse in the middle of traffic.
        #2;
        reset = 1'b1;
        #1;
        check("areset_count", 64'(fq_count), 64'd0);
        check("areset_fq_valid", 64'(fq_out_valid), 64'd0);
        check("areset_inst_valid", 64'(inst_valid), 64'd0);
        check("areset_inst_addr", 64'(inst_addr), 64'(RESET_PC));
        pend.delete();
        sb.delete();
        hs_log.delete();
        pop_log.delete();
        epoch++;
        exp_addr  = RESET_PC;
        exp_fmask = 2'b11;
        repeat (2) step();
        reset = 1'b0;
        repeat (8) step();
        check("restart_issue", 64'(hs_log[0]), 64'(RESET_PC));
        check("restart_out", 64'(pop_log[0]), 64'(RESET_PC));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Decoupled instruction-fetch front end, a parametrised successor to the single-entry pre-IF/IF pair.
- Generates fetch-block addresses and keeps up to MAX_OUTST requests in flight on the icache request/response interface.
- Buffers returned fetch groups in an FQ_DEPTH-entry queue and presents one group per cycle to decode.
- On redirect, flushes the queue and silently drops responses that are still in flight.

Parameters:
- FETCH_WIDTH, 2, instructions per fetch group; power of 2, range 1..4.
- FQ_DEPTH, 8, fetch-queue entries; power of 2, at least 2.
- MAX_OUTST, 2, maximum in-flight icache requests, range 1..4.
- RESET_PC, 32'h1c000000, first fetch address after reset.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- redirect_valid  in  1  flush/branch redirect, already prioritised upstream
- redirect_pc  in  32  redirect target
- fetch_hold  in  1  idle lock; suppresses new requests only
- inst_valid  out  1  request valid
- inst_addr  out  32  block-aligned request address
- inst_addr_ok  in  1  request accepted
- inst_data_ok  in  1  response valid; responses return in order
- inst_rdata  in  32*FETCH_WIDTH  response words, slot 0 in the low bits
- inst_excp  in  1  fetch exception with this response (TLB refill, PIF, PPI)
- inst_excp_num  in  4  exception code
- fq_out_valid  out  1  head entry valid to decode
- fq_out_pc  out  32  PC of slot 0 of the head group (block-aligned)
- fq_out_inst  out  32*FETCH_WIDTH  head group instructions
- fq_out_mask  out  FETCH_WIDTH  valid-slot mask of the head group
- fq_out_excp  out  1  head exception flag
- fq_out_excp_num  out  4  head exception code
- ds_allowin  in  1  decode pops the head when fq_out_valid && ds_allowin
- fq_count  out  log2(FQ_DEPTH)+1  occupied entries

Behaviour:
- Reset (asynchronous): queue empty, outstanding=0, discard=0, fetch_pc=RESET_PC, first_mask=all ones, adef_pend=0.
  - Every output is 0 during reset except inst_addr=RESET_PC aligned.
- BLK = FETCH_WIDTH*4 bytes. inst_addr = fetch_pc with the low log2(BLK) bits cleared.
- Issue condition (combinational):
  - inst_valid = !reset && !redirect_valid && !fetch_hold && !adef_pend && outstanding<MAX_OUTST && (fq_count+outstanding)<FQ_DEPTH.
  - This credit rule guarantees every response has a slot; the queue never overflows.
- On inst_valid && inst_addr_ok:
  - outstanding+1.
  - fetch_pc <= aligned fetch_pc + BLK, 32-bit wrap.
  - A per-request mask FIFO (depth MAX_OUTST) pushes first_mask; first_mask then becomes all ones.
- Response handling (inst_data_ok):
  - discard>0: discard-1, response dropped, mask FIFO unchanged.
  - Otherwise: outstanding-1, pop the mask FIFO, enqueue {pc, rdata, mask, inst_excp, inst_excp_num}.
  - The pc field is taken from a per-request PC FIFO (depth MAX_OUTST) pushed at issue.
- A handshake and a response in the same cycle update outstanding by the net amount.
- Redirect (redirect_valid=1, single cycle), with priority over everything:
  - Queue cleared; an enqueue and a pop in the same cycle are both ignored.
  - discard <= discard + outstanding - (inst_data_ok && discard==0 ? 1 : 0) - (inst_data_ok && discard>0 ? 1 : 0).
  - outstanding <= 0; mask and PC FIFOs cleared.
  - No request is issued in the redirect cycle.
  - fetch_pc <= redirect_pc.
  - first_mask <= ones from slot redirect_pc[log2(BLK)-1:2] upward.
- ADEF: if redirect_pc[1:0]!=0, set adef_pend; no request is issued.
  - Once in-flight discards drain, enqueue one entry: mask=slot of pc, excp=1, excp_num=4'h1, pc=aligned.
  - After that entry is enqueued, hold issue until the next redirect.
- Back-to-back redirects accumulate discard correctly; discard never underflows.
- fetch_hold asserted mid-flight: already-issued requests complete and enqueue normally.
- Queue: circular buffer with head/tail pointers and a count.
  - Simultaneous push and pop when full or empty is legal: push while empty plus pop is impossible, since pop needs a valid head.
  - Outputs are registered from the head entry; an entry is visible the cycle after enqueue.
- Latency: addr_ok to data_ok is arbitrary; data_ok to fq_out_valid is 1 cycle.

Test Plan:
- Reset release, FETCH_WIDTH=2, always-ready cache with 1-cycle data:
  - inst_addr sequence 1c000000, 1c000008, 1c000010.
  - fq_out_pc follows the same sequence, mask=2'b11.
- ds_allowin=0 held for 20 cycles:
  - fq_count saturates at 8, inst_valid drops once fq_count+outstanding=8.
  - No entry is lost after ds_allowin=1.
- Two requests in flight, then redirect to 1c000104:
  - Both stale responses are dropped; the next entry has pc=1c000100, mask=2'b10.
- Redirect to 1c000102:
  - No request issued; exactly one entry with excp=1, excp_num=1.
  - inst_valid stays 0 until the next redirect.
- Redirect asserted in the same cycle as inst_data_ok with discard=0 and outstanding=2:
  - discard=1, the queue stays empty, and the following response is dropped.
- Asynchronous reset pulse mid-transfer:
  - All counters clear immediately; fetch restarts at 1c000000 after release.
